xbus_slave_bridge_p: RTL and testbench
======================================

Name: xbus_slave_bridge_p

Overview:
Parametrised single-clock successor to the xbus slave bridge. Decodes 24-bit xbus link words (4-bit opcode, 20-bit payload) into Wishbone-classic master cycles of configurable data/address width. Returns read data and a status word over the outgoing xbus link, paced by an external transmit-slot enable. Adds bus timeout with error reporting, overrun detection and selectable posted writes. Sits between the xbus PHY/link layer and the SoC system bus.

Parameters:
DBW, 128, data width; multiple of 16, range 16..128; chunks NCH = DBW/16, sel width DBW/8
ABW, 32, address width; range 21..32
TO_CYCLES, 1023, bus cycles without ack_i before timeout; range 1..65535

Ports:
clk_i  in  1  sole clock, link and bus
rst_i  in  1  asynchronous active-high reset
cyc_o  out  1  Wishbone cycle
stb_o  out  1  Wishbone strobe
ack_i  in  1  Wishbone acknowledge
we_o  out  1  write enable
sel_o  out  DBW/8  byte selects
adr_o  out  ABW  address
dat_o  out  DBW  write data
dat_i  in  DBW  read data
xb_dat_i  in  24  incoming link word, sampled every clk_i
xb_txen_i  in  1  outgoing slot available (link data-enable window)
xb_dat_o  out  24  outgoing link word
busy_o  out  1  high from start accept until status word sent or bus cycle ends

Behaviour:
- Reset: all outputs 0; internal adr/dat/sel/we holds 0; FSM IDLE; ovr flag 0. xb_dat_o = 0 is NOP.
- Rx decode, every cycle, xb_dat_i[23:20]:
  - 0 NOP.
  - 1: adr[19:0] <= pl[19:0].
  - 2: adr[ABW-1:20] <= pl[ABW-21:0].
  - 3 control: we <= pl[19]; sel <= pl[DBW/8-1:0]; start = pl[18].
  - 8+k, k < NCH: dat[16k+15:16k] <= pl[15:0].
  - 4..7 and 8+k with k >= NCH: ignored.
- Start in IDLE: next cycle cyc_o = stb_o = 1; we_o, sel_o, adr_o, dat_o loaded from holds (1-cycle latency). Go to BUS.
- Start outside IDLE: ignored; ovr <= 1 (sticky until next status word is sent).
- BUS state:
  - ack_i high: capture dat_i; cyc_o, stb_o, we_o, sel_o <= 0 the next cycle; err <= 0.
  - Otherwise a 16-bit counter increments. When it reaches TO_CYCLES, terminate the bus cycle the same way with err <= 1.
  - Next state: RDATA if read and not err, else STAT.
- RDATA: step through chunks k ascending where captured sel[2k+1:2k] != 0, one chunk per enabled slot: xb_dat_o = {4'h8+k, 4'h0, data[16k+15:16k]}. Zero-select chunks are skipped without consuming a slot. After the last chunk, or immediately if none are selected, go to STAT.
- STAT: xb_dat_o = {4'h3, 1'b0, ack=1, complete=1, err, ovr, 15'h0}. Clear ovr. Go to IDLE.
- Slot pacing: xb_txen_i low gives xb_dat_o = NOP and the FSM holds in RDATA/STAT. Only enabled cycles emit or advance. In IDLE, xb_dat_o = NOP.
- ack_i arriving after timeout, or while cyc_o is low: ignored.
- Control-word field order is fixed by the pl[] bit positions above. Rx decode continues during BUS/RDATA; holds update but the active cycle is unaffected.
- Async reset mid-cycle: cyc_o drops immediately; no status word is sent.

Optional Feature:
XBUS_WRITE_ACK_EN
- Defined: a completed write (or write timeout) produces the STAT word as above.
- Undefined: writes are posted. After bus termination the FSM returns to IDLE with no STAT word. A write timeout is recorded in err and ovr, and reported in the next read's STAT word.

Test Plan:
- DBW=128: words 1/05678, 2/0ABC, 3 with we=0, start=1, sel=FFFF; ack after 3 cycles with dat_i=0x...0F0E..01 -> adr_o=0xABC05678; cyc_o high 1 cycle after the start word; 8 data words opcodes 8..F in order, then status 0x360000.
- Read with sel=0x00F0 -> only opcodes A and B emitted, then status.
- ack_i never asserted, TO_CYCLES=15 -> cyc_o drops after 15 cycles; no data words; status 0x370000 (err=1).
- xb_txen_i toggling 1-0-1 during RDATA -> NOP in low cycles; no chunk lost or duplicated.
- Second start during BUS -> ignored; status 0x368000 (ovr=1); next status has ovr=0.
- Write with the macro defined -> dat_o equals the loaded chunks; status 0x360000. With the macro undefined -> no status; busy_o low after termination.

Source files
------------

// File: rtl/xbus_slave_bridge_p.sv
// xbus link-word decoder driving a Wishbone-classic master, with read-data/status return.
// Optional XBUS_WRITE_ACK_EN: writes return a status word; otherwise writes are posted.
module xbus_slave_bridge_p #(
  parameter int DBW       = 128,
  parameter int ABW       = 32,
  parameter int TO_CYCLES = 1023
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              cyc_o,
  output logic              stb_o,
  input  logic              ack_i,
  output logic              we_o,
  output logic [DBW/8-1:0]  sel_o,
  output logic [ABW-1:0]    adr_o,
  output logic [DBW-1:0]    dat_o,
  input  logic [DBW-1:0]    dat_i,
  input  logic [23:0]       xb_dat_i,
  input  logic              xb_txen_i,
  output logic [23:0]       xb_dat_o,
  output logic              busy_o
);

  localparam int NCH  = DBW / 16;
  localparam int SELW = DBW / 8;
  localparam logic [15:0] TO_LAST = 16'(TO_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUS, RDATA, STAT} state_t;

  state_t           state_q;
  logic [ABW-1:0]   adr_h;
  logic [DBW-1:0]   dat_h;
  logic [DBW-1:0]   rd_q;
  logic [NCH-1:0]   pend_q;
  logic [15:0]      cnt_q;
  logic             err_q;
  logic             werr_q;
  logic             ovr_q;

  logic [3:0]       rx_op;
  logic [19:0]      rx_pl;
  logic             rx_start;
  logic             bus_end;
  logic             posted_to;
  logic [NCH-1:0]   sel_mask;
  logic [NCH-1:0]   pend_clr;
  logic [2:0]       cur_k;
  logic [15:0]      cur_chunk;

  assign rx_op    = xb_dat_i[23:20];
  assign rx_pl    = xb_dat_i[19:0];
  assign rx_start = (rx_op == 4'h3) && rx_pl[18];
  assign bus_end  = ack_i || (cnt_q == TO_LAST);

`ifdef XBUS_WRITE_ACK_EN
  assign posted_to = 1'b0;
`else
  assign posted_to = (state_q == BUS) && we_o && !ack_i && (cnt_q == TO_LAST);
`endif

  // Address and write-data holds track the link continuously; the bus cycle
  // snapshots them at start, so later updates never disturb an active cycle.
  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      adr_h <= '0;
      dat_h <= '0;
    end else begin
      case (rx_op)
        4'h1:    adr_h[19:0]     <= rx_pl;
        4'h2:    adr_h[ABW-1:20] <= rx_pl[ABW-21:0];
        default: begin
          for (int k = 0; k < NCH; k++)
            if (rx_op == 4'(8 + k)) dat_h[16*k +: 16] <= rx_pl[15:0];
        end
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    sel_mask  = '0;
    pend_clr  = '0;
    cur_k     = '0;
    cur_chunk = '0;
    for (int k = 0; k < NCH; k++) sel_mask[k] = |sel_o[2*k +: 2];
    for (int k = NCH - 1; k >= 0; k--)
      if (pend_q[k]) cur_k = 3'(k);
    for (int k = 0; k < NCH; k++) begin
      pend_clr[k] = pend_q[k] && (cur_k != 3'(k));
      if (cur_k == 3'(k)) cur_chunk = rd_q[16*k +: 16];
    end
  end

  // The return word is gated by the slot enable in the same cycle so it lands
  // inside the window the link layer marks.
  always_comb begin
    xb_dat_o = '0;
    if (xb_txen_i) begin
      case (state_q)
        RDATA:   xb_dat_o = {4'h8 + {1'b0, cur_k}, 4'h0, cur_chunk};
        STAT:    xb_dat_o = {4'h3, 1'b0, 1'b1, 1'b1, err_q | werr_q, ovr_q, 15'h0};
        default: xb_dat_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cyc_o   <= 1'b0;
      stb_o   <= 1'b0;
      we_o    <= 1'b0;
      sel_o   <= '0;
      adr_o   <= '0;
      dat_o   <= '0;
      rd_q    <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      werr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_start) begin
            cyc_o   <= 1'b1;
            stb_o   <= 1'b1;
            we_o    <= rx_pl[19];
            sel_o   <= rx_pl[SELW-1:0];
            adr_o   <= adr_h;
            dat_o   <= dat_h;
            cnt_q   <= '0;
            busy_o  <= 1'b1;
            state_q <= BUS;
          end
        end
        BUS: begin
          if (bus_end) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            we_o  <= 1'b0;
            sel_o <= '0;
            err_q <= !ack_i;
            if (ack_i) rd_q <= dat_i;
            if (!we_o && ack_i) begin
              pend_q  <= sel_mask;
              state_q <= (|sel_mask) ? RDATA : STAT;
            end else if (we_o) begin
`ifdef XBUS_WRITE_ACK_EN
              state_q <= STAT;
`else
              state_q <= IDLE;
              busy_o  <= 1'b0;
              if (posted_to) werr_q <= 1'b1;
`endif
            end else begin
              state_q <= STAT;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RDATA: begin
          if (xb_txen_i) begin
            pend_q <= pend_clr;
            if (!(|pend_clr)) state_q <= STAT;
          end
        end
        STAT: begin
          if (xb_txen_i) begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
            werr_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase

      // A new overrun wins over the clear issued by the status word it coincides with.
      if ((rx_start && state_q != IDLE) || posted_to) ovr_q <= 1'b1;
      else if (state_q == STAT && xb_txen_i)           ovr_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xbus_slave_bridge_p.sv
// Bench for xbus_slave_bridge_p: transaction-level model with per-cycle output comparison,
// directed scenarios with literal expectations, then randomized transactions.
module tb_xbus_slave_bridge_p;

  localparam int DBW  = 128;
  localparam int ABW  = 32;
  localparam int TO   = 15;
  localparam int NCH  = DBW / 16;
  localparam int SELW = DBW / 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              cyc_o, stb_o, ack_i, we_o, busy_o, xb_txen_i;
  logic [SELW-1:0]   sel_o;
  logic [ABW-1:0]    adr_o;
  logic [DBW-1:0]    dat_o, dat_i;
  logic [23:0]       xb_dat_i, xb_dat_o;

  xbus_slave_bridge_p #(.DBW(DBW), .ABW(ABW), .TO_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cyc_o(cyc_o), .stb_o(stb_o), .ack_i(ack_i),
    .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i),
    .xb_dat_i(xb_dat_i), .xb_txen_i(xb_txen_i), .xb_dat_o(xb_dat_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_err    = 0;

  bit              chk_en = 1'b0;
  bit              exp_cyc, bus_phase, tx_on;
  logic [ABW-1:0]  exp_adr;
  logic [DBW-1:0]  exp_dat;
  logic [SELW-1:0] exp_sel;
  logic            exp_we;
  logic [23:0]     exp_q[$];
  logic [23:0]     seen[$];
  bit              m_ovr, m_werr;
  int              cyc_hi;
  logic [ABW-1:0]  last_adr;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model's expectations for this cycle.
  always @(negedge clk_i) begin
    if (chk_en) begin
      check("cyc_o", cyc_o, exp_cyc);
      check("stb_o", stb_o, exp_cyc);
      check("busy_o", busy_o, bus_phase | tx_on);
      if (exp_cyc) begin
        check("adr_o", adr_o, exp_adr);
        check("dat_o", dat_o, exp_dat);
        check("sel_o", sel_o, exp_sel);
        check("we_o", we_o, exp_we);
      end else begin
        check("we_o_idle", we_o, 0);
        check("sel_o_idle", sel_o, 0);
      end
      if (cyc_o) begin
        cyc_hi++;
        last_adr = adr_o;
      end
      if (xb_dat_o != 24'h0) seen.push_back(xb_dat_o);
      if (xb_txen_i && tx_on && exp_q.size() > 0) begin
        check("xb_word", xb_dat_o, exp_q[0]);
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) tx_on = 1'b0;
      end else begin
        check("xb_nop", xb_dat_o, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Link traffic that never starts a cycle: NOP, address, junk opcodes, data chunks.
  function automatic logic [23:0] noise();
    int r;
    logic [3:0] op;
    r = $urandom_range(0, 9);
    if (r == 0)      op = 4'h0;
    else if (r == 1) op = 4'h1;
    else if (r == 2) op = 4'h2;
    else if (r == 3) op = 4'(4 + $urandom_range(0, 3));
    else             op = 4'(8 + $urandom_range(0, 7));
    return {op, 20'($urandom)};
  endfunction

  // ack_dly: bus cycle index at which ack_i is raised; <0 or >=TO means timeout.
  // tx_mode: 0 random slots, 1 every slot, 2 alternating starting enabled.
  task automatic run_txn(input bit we, input logic [SELW-1:0] sel, input logic [ABW-1:0] adr,
                         input logic [DBW-1:0] wdat, input logic [DBW-1:0] rdat,
                         input int ack_dly, input bit extra, input int tx_mode);
    int  term;
    bit  err;
    bit  want_stat;
    seen.delete();
    cyc_hi = 0;
    xb_dat_i = {4'h1, adr[19:0]};               tick();
    xb_dat_i = {4'h2, 8'($urandom), adr[31:20]}; tick();
    for (int k = 0; k < NCH; k++) begin
      xb_dat_i = {4'(8 + k), 4'($urandom), wdat[16*k +: 16]};
      tick();
    end
    xb_dat_i = {4'h5, 20'hFFFFF};               tick();
    exp_adr = adr; exp_dat = wdat; exp_sel = sel; exp_we = we;
    xb_dat_i = {4'h3, we, 1'b1, 2'b00, sel};    tick();
    bus_phase = 1'b1;
    exp_cyc   = 1'b1;
    if (ack_dly >= 0 && ack_dly < TO) begin term = ack_dly; err = 1'b0; end
    else                              begin term = TO - 1;  err = 1'b1; end
    for (int j = 0; j <= term; j++) begin
      ack_i = (j == ack_dly);
      dat_i = (j == ack_dly) ? rdat : {4{$urandom}};
      if (extra && j == ((term > 0) ? 1 : 0)) begin
        xb_dat_i = {4'h3, 1'($urandom), 1'b1, 2'b00, 16'($urandom)};
        m_ovr = 1'b1;
      end else begin
        xb_dat_i = noise();
      end
      xb_txen_i = 1'($urandom_range(0, 1));
      tick();
    end
    ack_i     = 1'b0;
    exp_cyc   = 1'b0;
    bus_phase = 1'b0;
    if (!we && !err)
      for (int k = 0; k < NCH; k++)
        if (sel[2*k +: 2] != 2'b00) exp_q.push_back({4'(8 + k), 4'h0, rdat[16*k +: 16]});
    want_stat = !we;
`ifdef XBUS_WRITE_ACK_EN
    want_stat = 1'b1;
`endif
    if (want_stat) begin
      exp_q.push_back({4'h3, 1'b0, 1'b1, 1'b1, err | m_werr, m_ovr, 15'h0});
      m_ovr  = 1'b0;
      m_werr = 1'b0;
    end else if (err) begin
      m_werr = 1'b1;
      m_ovr  = 1'b1;
    end
    tx_on = (exp_q.size() > 0);
    for (int c = 0; c < 300; c++) begin
      xb_txen_i = (tx_mode == 1) ? 1'b1 : (tx_mode == 2) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
      ack_i     = (c == 0) && (ack_dly >= TO);
      xb_dat_i  = noise();
      tick();
      if (!tx_on) break;
    end
    check("tx_drained", tx_on, 0);
    exp_q.delete();
    tx_on    = 1'b0;
    ack_i    = 1'b0;
    xb_dat_i = 24'h0;
    tick();
  endtask

  initial begin
    logic [DBW-1:0] rd1, wd;
    rst_i = 1'b1; ack_i = 1'b0; dat_i = '0; xb_dat_i = 24'h0; xb_txen_i = 1'b1;
    exp_cyc = 1'b0; bus_phase = 1'b0; tx_on = 1'b0; m_ovr = 1'b0; m_werr = 1'b0;
    exp_adr = '0; exp_dat = '0; exp_sel = '0; exp_we = 1'b0;
    tick(); tick();
    check("rst_cyc", cyc_o, 0);
    check("rst_stb", stb_o, 0);
    check("rst_we", we_o, 0);
    check("rst_sel", sel_o, 0);
    check("rst_adr", adr_o, 0);
    check("rst_dat", dat_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_xb", xb_dat_o, 0);
    rst_i = 1'b0;
    tick();
    chk_en = 1'b1;

    // Full 8-chunk read with ack after 3 wait cycles.
    rd1 = 128'h100F0E0D0C0B0A090807060504030201;
    run_txn(1'b0, 16'hFFFF, 32'hABC05678, {4{$urandom}}, rd1, 3, 1'b0, 1);
    check("t1_adr", last_adr, 32'hABC05678);
    check("t1_cyc_len", cyc_hi, 4);
    check("t1_nwords", seen.size(), 9);
    if (seen.size() == 9) begin
      check("t1_first", seen[0], 24'h800201);
      check("t1_last_chunk", seen[7], 24'hF0100F);
      check("t1_status", seen[8], 24'h360000);
    end

    // Sparse select: only chunks 2 and 3.
    run_txn(1'b0, 16'h00F0, 32'h12345678, {4{$urandom}}, {4{$urandom}}, 1, 1'b0, 1);
    check("t2_nwords", seen.size(), 3);
    if (seen.size() == 3) begin
      check("t2_op_a", seen[0][23:20], 4'hA);
      check("t2_op_b", seen[1][23:20], 4'hB);
      check("t2_status", seen[2], 24'h360000);
    end

    // No ack: timeout after TO cycles, status only.
    run_txn(1'b0, 16'hFFFF, 32'h00000040, {4{$urandom}}, {4{$urandom}}, -1, 1'b0, 1);
    check("t3_cyc_len", cyc_hi, TO);
    check("t3_nwords", seen.size(), 1);
    if (seen.size() == 1) check("t3_status", seen[0], 24'h370000);

    // Alternating slot enable during data return.
    run_txn(1'b0, 16'hFFFF, 32'h00F0F000, {4{$urandom}}, {4{$urandom}}, 1, 1'b0, 2);
    check("t4_nwords", seen.size(), 9);

    // Second start during the bus cycle flags overrun, cleared by the next status.
    run_txn(1'b0, 16'h0003, 32'h00000100, {4{$urandom}}, {4{$urandom}}, 5, 1'b1, 1);
    if (seen.size() > 0) check("t5_status_ovr", seen[seen.size()-1], 24'h368000);
    else                 check("t5_status_ovr_present", seen.size(), 2);
    run_txn(1'b0, 16'h0003, 32'h00000104, {4{$urandom}}, {4{$urandom}}, 0, 1'b0, 1);
    if (seen.size() > 0) check("t5_status_clr", seen[seen.size()-1], 24'h360000);
    else                 check("t5_status_clr_present", seen.size(), 2);

    // Write: dat_o carries the loaded chunks; status depends on the build option.
    wd = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    run_txn(1'b1, 16'hFFFF, 32'h80000000, wd, {4{$urandom}}, 2, 1'b0, 1);
    check("t6_dat_o", dat_o, wd);
`ifdef XBUS_WRITE_ACK_EN
    check("t6_nwords", seen.size(), 1);
    if (seen.size() == 1) check("t6_status", seen[0], 24'h360000);
`else
    check("t6_nwords", seen.size(), 0);
`endif
    check("t6_busy_after", busy_o, 0);

    // Write timeout, then a read that reports it.
    run_txn(1'b1, 16'h00FF, 32'h80000010, {4{$urandom}}, {4{$urandom}}, -1, 1'b0, 1);
    run_txn(1'b0, 16'h0000, 32'h80000020, {4{$urandom}}, {4{$urandom}}, 0, 1'b0, 1);
    check("t7_nwords", seen.size(), 1);
`ifdef XBUS_WRITE_ACK_EN
    if (seen.size() == 1) check("t7_status", seen[0], 24'h360000);
`else
    if (seen.size() == 1) check("t7_status", seen[0], 24'h378000);
`endif

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      logic [SELW-1:0] s;
      s = ($urandom_range(0, 3) == 0) ? '0 : 16'($urandom);
      run_txn(1'($urandom_range(0, 1)), s, 32'($urandom), {4{$urandom}}, {4{$urandom}},
              $urandom_range(0, 21) - 1, ($urandom_range(0, 5) == 0), $urandom_range(0, 2));
    end

    // Asynchronous reset in the middle of a bus cycle.
    chk_en   = 1'b0;
    xb_dat_i = {4'h3, 1'b0, 1'b1, 2'b00, 16'hFFFF};
    tick();
    xb_dat_i = 24'h0;
    check("pre_rst_cyc", cyc_o, 1);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_cyc", cyc_o, 0);
    check("async_rst_busy", busy_o, 0);
    exp_q.delete(); tx_on = 1'b0; bus_phase = 1'b0; exp_cyc = 1'b0; m_ovr = 1'b0; m_werr = 1'b0;
    tick();
    rst_i = 1'b0;
    xb_txen_i = 1'b1;
    ack_i = 1'b1;
    seen.delete();
    tick();
    chk_en = 1'b1;
    ack_i = 1'b0;
    repeat (10) tick();
    check("post_rst_silent", seen.size(), 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
